dc_ref_feeder: RTL
==================

# dc_ref_feeder

Sequencer that drives the reference-sample side of `DC_PRED_UNIT` for one prediction unit (PU) of 4x4 to 64x64.
- Reads packed neighbour samples (4 per word) from the top and left neighbour line buffers.
- Substitutes 128 for any unavailable side.
- Emits the exact `LEFT_VALID`/`TOP_VALID`/`DCVAL_flag` strobe sequence the DC unit needs to accumulate, normalise and output DC_VAL.
- Sits between the intra neighbour buffers and the DC predictor in the intra prediction path.

## Interface
Parameters:
- ADDR_W, 4, word address width of each neighbour buffer (16 words = 64 samples).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only when busy=0.
- pu_size  in  3  0=4x4, 1=8x8, 2=16x16, 3=32x32, 4..7=64x64.
- top_avail, left_avail  in  1 each  neighbour availability; sampled with start.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at end of job.
- top_rd_en, left_rd_en  out  1 each  buffer read enables.
- top_rd_addr, left_rd_addr  out  ADDR_W each  word addresses.
- top_rd_data, left_rd_data  in  32 each  synchronous-read data, 1-cycle latency; sample 4k+i in bits [8i+7:8i].
- PU  out  3  latched pu_size (values 5..7 are forwarded as 4).
- LEFT_VALID, TOP_VALID, DCVAL_flag  out  1 each  DC-unit strobes.
- TOP_REF0..TOP_REF3, LEFT_REF0..LEFT_REF3  out  8 each  REFi = byte i of the current word.

## Operation
- Cycle numbering: cycle n is the nth clock period after the edge that samples start=1 while idle.
- Cycle 1: busy rises, PU updates, and availability is latched.
- G = N/4 groups per side: PU0→1, PU1→2, PU2→4, PU3→8, PU4→16.
- Slot schedule for PU0 is a single slot 0 (COMBINED): L=1, T=1, flag=1, with top word 0 and left word 0.
- Slot schedule for PU≥1:
  - slot 0 CLR: L=0, T=0, flag=1, REF=0. This zeroes the DC accumulator.
  - slots 1..G, LEFT: L=1, T=0, flag=0, left word s-1.
  - slots G+1..2G, TOP: L=0, T=1, flag=0, top word s-G-1.
  - slot 2G+1, FLAG: L=0, T=0, flag=1, REF=0.
- FSM: IDLE → (CLR → LEFT → TOP → FLAG | COMBINED) → DRAIN → IDLE.
  - DRAIN covers the two-cycle pipeline tail.
  - Word counter counts 0..G-1 within LEFT and within TOP.
- Reads:
  - Reads are issued only for an available side; rd_en is never asserted for an unavailable side or for CLR/FLAG.
  - Addresses increment from 0 without wrap. Maximum address is G-1 ≤ 15.
- Substitution: for an unavailable side, the REF outputs are all 8'h80 for every slot of that side.
- The strobes are asserted regardless of availability; availability changes only sample values.
- Outputs are all registered. When no slot is presented, strobes and REF outputs are 0. PU holds until the next accepted start.

## Timing
- Pipeline: slot s read is issued in cycle s+1, RAM data arrives in cycle s+2, strobes and REF are presented in cycle s+3.
- Exactly one slot is presented per cycle, with no bubbles.
- Final slot: presented in cycle 3 for PU0, otherwise in cycle 2G+4.
- done pulses in the cycle after the final slot.
- busy is high from cycle 1 through the done cycle inclusive and falls the next cycle.
- start while busy, including in the done cycle, is ignored; it is not queued. The next start is accepted the cycle after done.
- Reset value of every output is 0: busy, done, rd_en, addrs, PU, strobes, REF.
- rst_n low at any point returns the FSM to IDLE immediately (asynchronous). Outputs are 0 and no done is issued.
- The first job after reset always begins with CLR (PU≥1), so the DC-unit state is deterministic.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0, busy=0. Deassert, idle 5 cycles → no rd_en, no strobes.
- PU0, both sides available, top word 0x04030201, left word 0x08070605:
  - cycle 3: L=T=flag=1, TOP_REF0..3=1,2,3,4, LEFT_REF0..3=5,6,7,8.
  - done in cycle 4, one read per side at address 0.
- PU1, left words 0x10101010/0x20202020, top words 0x30303030/0x40404040:
  - cycle 3 CLR (flag=1 only), cycles 4–5 LEFT with refs 0x10 then 0x20, cycles 6–7 TOP with 0x30 then 0x40, cycle 8 FLAG.
  - done in cycle 9. With the DC unit attached, DC_VAL = 0x28.
- PU4 (and again with pu_size=7), top_avail=0:
  - top_rd_en stays 0, left addresses run 0..15, all 16 TOP slots carry 0x80.
  - FLAG in cycle 36, done in cycle 37, PU output = 4 both times.
- PU3 job with rst_n pulsed low during cycle 6 → outputs 0 in the same cycle, no done. A new PU1 start then reproduces the PU1 sequence exactly.
- start pulsed during cycles 2, 5 and the done cycle of a PU1 job → all ignored. start in the cycle after done is accepted, and busy rises in the following cycle.

Source files
------------

// File: rtl/dc_ref_feeder_if.sv
// Read-side bus between the DC reference feeder and the top/left neighbour line buffers.
// The master drives enables/addresses; the slave returns data one cycle later.
interface dc_ref_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              top_rd_en;
  logic [ADDR_W-1:0] top_rd_addr;
  logic [31:0]       top_rd_data;
  logic              left_rd_en;
  logic [ADDR_W-1:0] left_rd_addr;
  logic [31:0]       left_rd_data;

  modport master (
    output top_rd_en, top_rd_addr, left_rd_en, left_rd_addr,
    input  top_rd_data, left_rd_data
  );

  modport slave (
    input  top_rd_en, top_rd_addr, left_rd_en, left_rd_addr,
    output top_rd_data, left_rd_data
  );
endinterface

// File: rtl/dc_ref_feeder.sv
// Sequences neighbour-buffer reads and DC-unit strobes for one PU (4x4..64x64).
// Three-stage pipe: issue read -> buffer data -> registered strobes/refs.
module dc_ref_feeder #(
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       pu_size,
  input  logic             top_avail,
  input  logic             left_avail,
  output logic             busy,
  output logic             done,
  dc_ref_feeder_if.master  nbr,
  output logic [2:0]       PU,
  output logic             LEFT_VALID,
  output logic             TOP_VALID,
  output logic             DCVAL_flag,
  output logic [7:0]       TOP_REF0,
  output logic [7:0]       TOP_REF1,
  output logic [7:0]       TOP_REF2,
  output logic [7:0]       TOP_REF3,
  output logic [7:0]       LEFT_REF0,
  output logic [7:0]       LEFT_REF1,
  output logic [7:0]       LEFT_REF2,
  output logic [7:0]       LEFT_REF3
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LEFT,
    TOP,
    FLAG,
    COMBINED,
    DRAIN
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] g_last;
  logic [2:0] pu_q;
  logic       top_av_q;
  logic       left_av_q;

  // Slot kind travelling alongside the read: stage 1 (read issued) and stage 2 (data back).
  logic p1_l, p1_t, p1_f;
  logic p2_l, p2_t, p2_f;

  assign PU = pu_q;

  always_comb begin
    g_last = 4'd0;
    case (pu_q)
      3'd0:    g_last = 4'd0;
      3'd1:    g_last = 4'd1;
      3'd2:    g_last = 4'd3;
      3'd3:    g_last = 4'd7;
      default: g_last = 4'd15;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pu_q             <= '0;
      top_av_q         <= 1'b0;
      left_av_q        <= 1'b0;
      nbr.top_rd_en    <= 1'b0;
      nbr.left_rd_en   <= 1'b0;
      nbr.top_rd_addr  <= '0;
      nbr.left_rd_addr <= '0;
      p1_l             <= 1'b0;
      p1_t             <= 1'b0;
      p1_f             <= 1'b0;
    end else begin
      done           <= 1'b0;
      nbr.top_rd_en  <= 1'b0;
      nbr.left_rd_en <= 1'b0;
      p1_l           <= 1'b0;
      p1_t           <= 1'b0;
      p1_f           <= 1'b0;
      case (state)
        IDLE: begin
          // busy still high here means this is the done cycle; starts are dropped
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy             <= 1'b1;
            pu_q             <= (pu_size > 3'd4) ? 3'd4 : pu_size;
            top_av_q         <= top_avail;
            left_av_q        <= left_avail;
            nbr.top_rd_addr  <= '0;
            nbr.left_rd_addr <= '0;
            cnt              <= '0;
            if (pu_size == 3'd0) begin
              state          <= COMBINED;
              nbr.top_rd_en  <= top_avail;
              nbr.left_rd_en <= left_avail;
              p1_l           <= 1'b1;
              p1_t           <= 1'b1;
              p1_f           <= 1'b1;
            end else begin
              state <= CLR;
              p1_f  <= 1'b1;
            end
          end
        end
        CLR: begin
          state            <= LEFT;
          cnt              <= '0;
          nbr.left_rd_en   <= left_av_q;
          nbr.left_rd_addr <= '0;
          p1_l             <= 1'b1;
        end
        LEFT: begin
          if (cnt == g_last) begin
            state           <= TOP;
            cnt             <= '0;
            nbr.top_rd_en   <= top_av_q;
            nbr.top_rd_addr <= '0;
            p1_t            <= 1'b1;
          end else begin
            cnt              <= cnt + 4'd1;
            nbr.left_rd_en   <= left_av_q;
            nbr.left_rd_addr <= ADDR_W'(cnt + 4'd1);
            p1_l             <= 1'b1;
          end
        end
        TOP: begin
          if (cnt == g_last) begin
            state <= FLAG;
            cnt   <= '0;
            p1_f  <= 1'b1;
          end else begin
            cnt             <= cnt + 4'd1;
            nbr.top_rd_en   <= top_av_q;
            nbr.top_rd_addr <= ADDR_W'(cnt + 4'd1);
            p1_t            <= 1'b1;
          end
        end
        FLAG, COMBINED: begin
          state <= DRAIN;
          cnt   <= '0;
        end
        DRAIN: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Presentation stage: unavailable sides read nothing and present the mid-grey 0x80.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_l       <= 1'b0;
      p2_t       <= 1'b0;
      p2_f       <= 1'b0;
      LEFT_VALID <= 1'b0;
      TOP_VALID  <= 1'b0;
      DCVAL_flag <= 1'b0;
      {TOP_REF3, TOP_REF2, TOP_REF1, TOP_REF0}     <= 32'h0;
      {LEFT_REF3, LEFT_REF2, LEFT_REF1, LEFT_REF0} <= 32'h0;
    end else begin
      p2_l       <= p1_l;
      p2_t       <= p1_t;
      p2_f       <= p1_f;
      LEFT_VALID <= p2_l;
      TOP_VALID  <= p2_t;
      DCVAL_flag <= p2_f;
      {TOP_REF3, TOP_REF2, TOP_REF1, TOP_REF0} <=
        p2_t ? (top_av_q ? nbr.top_rd_data : 32'h80808080) : 32'h0;
      {LEFT_REF3, LEFT_REF2, LEFT_REF1, LEFT_REF0} <=
        p2_l ? (left_av_q ? nbr.left_rd_data : 32'h80808080) : 32'h0;
    end
  end

endmodule
